// File: rtl/toa_arbiter_if.sv
// Time-of-arrival arbiter bus: per-channel capture inputs and frame output.
// The arbiter sits on the slave side, the capture/consumer environment on master.
interface toa_arbiter_if;
    logic [127:0] ch_time;
    logic [3:0]   ch_valid;
    logic [3:0]   ch_ack;
    logic         frm_valid;
    logic         frm_ready;
    logic [127:0] frm_time;
    logic [127:0] frm_dt;
    logic [3:0]   frm_mask;
    logic [1:0]   frm_first;
    logic         frm_timeout;

    modport slave (
        input  ch_time,
        input  ch_valid,
        input  frm_ready,
        output ch_ack,
        output frm_valid,
        output frm_time,
        output frm_dt,
        output frm_mask,
        output frm_first,
        output frm_timeout
    );

    modport master (
        output ch_time,
        output ch_valid,
        output frm_ready,
        input  ch_ack,
        input  frm_valid,
        input  frm_time,
        input  frm_dt,
        input  frm_mask,
        input  frm_first,
        input  frm_timeout
    );
endinterface

// File: rtl/toa_arbiter.sv
// Four-channel time-of-arrival arbiter: collects timer captures into a frame
// within a window, round-robin one grant per cycle, reports deltas to first.
module toa_arbiter #(
    parameter logic [15:0] WINDOW = 16'd1024
) (
    input  logic         clk,
    input  logic         rst,
    toa_arbiter_if.slave bus
);

    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] OUTPUT  = 2'd2;

    localparam logic [15:0] WLAST = WINDOW - 16'd1;

    logic [1:0]   state;
    logic [1:0]   rr_ptr;
    logic [15:0]  win_cnt;
    logic [3:0]   ack_q;
    logic [127:0] time_q;
    logic [3:0]   mask_q;
    logic [1:0]   first_q;
    logic         tmo_q;

    logic [3:0]   elig;
    logic         gnt_vld;
    logic [1:0]   gnt_idx;
    logic [1:0]   cand;
    logic [3:0]   gnt_oh;
    logic [3:0]   mask_nxt;
    logic [31:0]  first_t;

    // Channels that may be granted this cycle; ack cycle blocks a re-grant.
    always_comb begin
        elig = bus.ch_valid & ~mask_q & ~ack_q;
        if (state == OUTPUT) begin
            elig = 4'b0000;
        end
    end

    // Round-robin pick, highest priority at rr_ptr.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = 2'd0;
        cand    = 2'd0;
        for (int j = 0; j < 4; j++) begin
            cand = rr_ptr + 2'(j);
            if (!gnt_vld && elig[cand]) begin
                gnt_vld = 1'b1;
                gnt_idx = cand;
            end
        end
    end

    assign gnt_oh   = gnt_vld ? (4'b0001 << gnt_idx) : 4'b0000;
    assign mask_nxt = mask_q | gnt_oh;

    // Deltas against the first capture; 32-bit wrap gives correct results.
    always_comb begin
        first_t    = time_q[{first_q, 5'b00000} +: 32];
        bus.frm_dt = '0;
        for (int i = 0; i < 4; i++) begin
            if (mask_q[i]) begin
                bus.frm_dt[32*i +: 32] = time_q[32*i +: 32] - first_t;
            end
        end
    end

    // Frame state machine, capture registers and one-cycle acks.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rr_ptr  <= 2'd0;
            win_cnt <= 16'd0;
            ack_q   <= 4'b0000;
            time_q  <= '0;
            mask_q  <= 4'b0000;
            first_q <= 2'd0;
            tmo_q   <= 1'b0;
        end else begin
            ack_q <= gnt_oh;
            if (gnt_vld) begin
                time_q[{gnt_idx, 5'b00000} +: 32] <=
                    bus.ch_time[{gnt_idx, 5'b00000} +: 32];
                rr_ptr <= gnt_idx + 2'd1;
            end
            unique case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        mask_q  <= mask_nxt;
                        first_q <= gnt_idx;
                        win_cnt <= 16'd0;
                        state   <= COLLECT;
                    end
                end
                COLLECT: begin
                    mask_q  <= mask_nxt;
                    win_cnt <= win_cnt + 16'd1;
                    if (mask_nxt == 4'b1111) begin
                        tmo_q <= 1'b0;
                        state <= OUTPUT;
                    end else if (win_cnt == WLAST) begin
                        tmo_q <= 1'b1;
                        state <= OUTPUT;
                    end
                end
                OUTPUT: begin
                    if (bus.frm_ready) begin
                        mask_q <= 4'b0000;
                        tmo_q  <= 1'b0;
                        time_q <= '0;
                        state  <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.ch_ack      = ack_q;
    assign bus.frm_valid   = (state == OUTPUT);
    assign bus.frm_time    = time_q;
    assign bus.frm_mask    = mask_q;
    assign bus.frm_first   = first_q;
    assign bus.frm_timeout = tmo_q;

endmodule
